norm_shift_sequencer: RTL and testbench
=======================================

NORM_SHIFT_SEQUENCER -- requirements
Module: norm_shift_sequencer

Interface
REQ-001 SHALL have parameter SWR, default 26: significand width in bits, including the hidden bit.
REQ-002 SHALL have parameter EWR, default 8: biased exponent width.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: request to normalize the loaded operand.
REQ-006 SHALL have port significand_i, input, SWR bits: unnormalized significand.
REQ-007 SHALL have port exponent_i, input, EWR bits: exponent associated with significand_i.
REQ-008 SHALL have port guard_i, input, 1 bit: fill bit for the first shift (present only under NORM_SHIFT_GUARD_EN).
REQ-009 SHALL have port busy_o, output, 1 bit: operation in progress.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port significand_o, output, SWR bits: normalized significand.
REQ-012 SHALL have port exponent_o, output, EWR bits: adjusted exponent.
REQ-013 SHALL have port shift_count_o, output, CW = clog2(SWR)+1 bits: number of shifts applied.
REQ-014 SHALL have port zero_o, output, 1 bit: operand was zero.
REQ-015 SHALL have port underflow_o, output, 1 bit: exponent reached 0 before the MSB was set.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 SHALL accept start_i only in IDLE: on that edge it loads significand_i/exponent_i, clears count and flags, and goes to SHIFT.
REQ-018 SHALL ignore start_i in SHIFT and DONE, with no queuing.
REQ-019 SHALL, in SHIFT, go to DONE without shifting when sig[SWR-1]=1, sig=0 or exp=0.
REQ-020 SHALL, in SHIFT when REQ-019 does not apply, set sig to sig shifted left by one with a zero fill, decrement exp by 1 and increment count by 1, at one shift per cycle.
REQ-021 SHALL set zero_o=1, exponent_o=0 and count=0 when sig=0 at SHIFT entry.
REQ-022 SHALL set underflow_o=1 when the loop exits on exp=0 while sig[SWR-1]=0 and sig≠0.
REQ-023 SHALL assert done_o for exactly one cycle in DONE, exactly k+1 cycles after the accepting edge, where k is the shift count; k never exceeds SWR-1.
REQ-024 SHALL hold busy_o=1 from the cycle after acceptance through DONE, and 0 otherwise.
REQ-025 SHALL hold significand_o, exponent_o, shift_count_o, zero_o and underflow_o stable from DONE until the next accepted start_i.
REQ-026 SHALL return from DONE to IDLE unconditionally.
REQ-027 SHALL never wrap the exponent below 0.

Reset
REQ-028 SHALL, on rst=1, immediately and asynchronously enter IDLE and zero every output, including during SHIFT.
REQ-029 SHALL emit no done_o for an operation aborted by reset.
REQ-030 SHALL accept start_i on the first clk edge after rst deasserts.

Configuration
REQ-031 SHALL, with NORM_SHIFT_GUARD_EN defined, include port guard_i and fill the first shift of each operation with guard_i, using 0 for later shifts.
REQ-032 SHALL, without NORM_SHIFT_GUARD_EN, omit guard_i and use zero fill for every shift.

Structure
REQ-033 SHALL take the state enum, the CW derivation and the default SWR/EWR from the shared package fpu_norm_pkg.
REQ-034 SHALL instantiate the datapath as a single sub-module norm_shift_stage: a one-bit left shift with a select and a fill bit, instantiated once per bit.

Verification (SWR=26, EWR=8)
REQ-035 SHALL test sig=0x0800000, exp=100: expect done_o 3 cycles after accept, sig_o=0x2000000, exp_o=98, count=2, flags 0.
REQ-036 SHALL test sig=0x2000001, exp=50: expect done_o 1 cycle after accept, outputs unchanged, count=0.
REQ-037 SHALL test sig=0x0000001, exp=3: expect sig_o=0x0000008, exp_o=0, count=3, underflow_o=1.
REQ-038 SHALL test sig=0: expect zero_o=1, exp_o=0, count=0, done_o 1 cycle after accept.
REQ-039 SHALL test start_i pulsed in SHIFT (ignored, single done_o), then rst at the 2nd shift of REQ-035 (outputs 0 at once, no done_o), then a fresh start completing correctly.
REQ-040 SHALL test, with NORM_SHIFT_GUARD_EN, sig=0x1000000, guard_i=1: expect sig_o=0x2000001, count=1.

Source files
------------

// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the normalization shift sequencer.
//   SWR_DEFAULT / EWR_DEFAULT : default significand / exponent widths
//   norm_state_e              : sequencer state encoding
//   cw_of()                   : shift-count width for a given significand width
package fpu_norm_pkg;

    localparam int SWR_DEFAULT = 26;
    localparam int EWR_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } norm_state_e;

    // Wide enough to hold SWR itself, so SWR-1 shifts never overflow.
    function automatic int cw_of(input int swr);
        return $clog2(swr) + 1;
    endfunction

endpackage

// File: rtl/norm_shift_stage.sv
// One bit of the left-shift datapath.
//   sel       : 1 = take the bit from the next lower position (shift), 0 = hold
//   keep_bit  : current value of this bit position
//   shift_bit : value of the next lower bit (or the fill bit for bit 0)
//   y         : resulting bit
module norm_shift_stage (
    input  logic sel,
    input  logic keep_bit,
    input  logic shift_bit,
    output logic y
);

    assign y = sel ? shift_bit : keep_bit;

endmodule

// File: rtl/norm_shift_sequencer.sv
// Iterative normalizer: shifts the significand left one bit per cycle until its
// MSB is set, decrementing the exponent per shift, stopping early on a zero
// operand or when the exponent reaches 0.
//   clk, rst              : clock, asynchronous active-high reset
//   start_i               : accepted only in IDLE
//   significand_i         : unnormalized significand (SWR bits)
//   exponent_i            : associated exponent (EWR bits)
//   guard_i               : fill bit for the first shift (NORM_SHIFT_GUARD_EN only)
//   busy_o, done_o        : operation in progress / one-cycle completion pulse
//   significand_o, exponent_o, shift_count_o : normalized result
//   zero_o, underflow_o   : status flags
// Build option: define NORM_SHIFT_GUARD_EN to add guard_i; otherwise all fills are 0.
//
// State  | meaning
// IDLE   | waiting for start_i
// SHIFT  | one left shift per cycle until normalized, zero or exponent 0
// DONE   | result valid, done_o high for this single cycle
module norm_shift_sequencer
    import fpu_norm_pkg::*;
#(
    parameter int SWR = SWR_DEFAULT,
    parameter int EWR = EWR_DEFAULT,
    localparam int CW = cw_of(SWR)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] significand_i,
    input  logic [EWR-1:0] exponent_i,
`ifdef NORM_SHIFT_GUARD_EN
    input  logic           guard_i,
`endif
    output logic           busy_o,
    output logic           done_o,
    output logic [SWR-1:0] significand_o,
    output logic [EWR-1:0] exponent_o,
    output logic [CW-1:0]  shift_count_o,
    output logic           zero_o,
    output logic           underflow_o
);

    norm_state_e state, state_next;

    logic [SWR-1:0] sig_q;
    logic [EWR-1:0] exp_q;
    logic [CW-1:0]  cnt_q;
    logic           zero_q;
    logic           uf_q;

    logic           sig_is_zero;
    logic           stop;
    logic           shift_en;
    logic           fill;
    logic [SWR-1:0] sig_shifted;

    assign sig_is_zero = (sig_q == '0);
    assign stop        = sig_q[SWR-1] | sig_is_zero | (exp_q == '0);
    assign shift_en    = (state == ST_SHIFT) && !stop;

`ifdef NORM_SHIFT_GUARD_EN
    // Guard bit is captured at acceptance and used only for the first shift.
    logic guard_q;
    logic first_q;
    assign fill = first_q & guard_q;
`else
    assign fill = 1'b0;
`endif

    for (genvar i = 0; i < SWR; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            norm_shift_stage u_stage (
                .sel       (shift_en),
                .keep_bit  (sig_q[0]),
                .shift_bit (fill),
                .y         (sig_shifted[0])
            );
        end else begin : g_bit
            norm_shift_stage u_stage (
                .sel       (shift_en),
                .keep_bit  (sig_q[i]),
                .shift_bit (sig_q[i-1]),
                .y         (sig_shifted[i])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_i) state_next = ST_SHIFT;
            ST_SHIFT: if (stop)    state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != ST_IDLE);
        done_o = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= '0;
            exp_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
`ifdef NORM_SHIFT_GUARD_EN
            guard_q <= 1'b0;
            first_q <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && start_i) begin
                sig_q  <= significand_i;
                exp_q  <= exponent_i;
                cnt_q  <= '0;
                zero_q <= 1'b0;
                uf_q   <= 1'b0;
`ifdef NORM_SHIFT_GUARD_EN
                guard_q <= guard_i;
                first_q <= 1'b1;
`endif
            end else if (state == ST_SHIFT) begin
                if (sig_is_zero) begin
                    zero_q <= 1'b1;
                    exp_q  <= '0;
                end else if (!sig_q[SWR-1] && exp_q == '0) begin
                    uf_q <= 1'b1;
                end else if (shift_en) begin
                    // shift_en implies exp_q > 0, so the decrement never wraps.
                    sig_q <= sig_shifted;
                    exp_q <= exp_q - 1'b1;
                    cnt_q <= cnt_q + 1'b1;
`ifdef NORM_SHIFT_GUARD_EN
                    first_q <= 1'b0;
`endif
                end
            end
        end
    end

    assign significand_o = sig_q;
    assign exponent_o    = exp_q;
    assign shift_count_o = cnt_q;
    assign zero_o        = zero_q;
    assign underflow_o   = uf_q;

endmodule

// File: tb/tb_norm_shift_sequencer.sv
module tb_norm_shift_sequencer;

    localparam int SWR = 26;
    localparam int EWR = 8;
    localparam int CW  = $clog2(SWR) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [SWR-1:0] significand_i = '0;
    logic [EWR-1:0] exponent_i = '0;
    logic           guard_i = 1'b0;
    logic           busy_o;
    logic           done_o;
    logic [SWR-1:0] significand_o;
    logic [EWR-1:0] exponent_o;
    logic [CW-1:0]  shift_count_o;
    logic           zero_o;
    logic           underflow_o;

    int checks = 0;
    int errors = 0;

    norm_shift_sequencer #(.SWR(SWR), .EWR(EWR)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .significand_i (significand_i),
        .exponent_i    (exponent_i),
`ifdef NORM_SHIFT_GUARD_EN
        .guard_i       (guard_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o),
        .significand_o (significand_o),
        .exponent_o    (exponent_o),
        .shift_count_o (shift_count_o),
        .zero_o        (zero_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [SWR-1:0] e_sig, input logic [EWR-1:0] e_exp,
                              input int e_cnt, input logic e_zero, input logic e_uf);
        chk({tag, "_sig"},  significand_o, e_sig);
        chk({tag, "_exp"},  exponent_o,    e_exp);
        chk({tag, "_cnt"},  shift_count_o, e_cnt);
        chk({tag, "_zero"}, zero_o,        e_zero);
        chk({tag, "_uf"},   underflow_o,   e_uf);
    endtask

    // Starts an operation, measures done_o latency in edges after the
    // accepting edge, checks the result and its stability after DONE.
    task automatic run_op(input string tag, input logic [SWR-1:0] sig, input logic [EWR-1:0] expn,
                          input logic g, input bit poke,
                          input int k, input logic [SWR-1:0] e_sig, input logic [EWR-1:0] e_exp,
                          input logic e_zero, input logic e_uf);
        int n;
        int dones;
        significand_i = sig;
        exponent_i    = expn;
        guard_i       = g;
        start_i       = 1'b1;
        step();
        start_i = 1'b0;
        chk({tag, "_busy_accept"}, busy_o, 1'b1);
        n = 0;
        dones = 0;
        while (!done_o && n < 60) begin
            if (poke && n == 0) begin
                significand_i = 26'h3FFFFFF;
                start_i = 1'b1;
            end
            step();
            start_i = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, n, k + 1);
        chk({tag, "_busy_done"}, busy_o, 1'b1);
        chk_result(tag, e_sig, e_exp, k, e_zero, e_uf);
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_o) dones++;
        end
        chk({tag, "_extra_done"}, dones, 0);
        chk({tag, "_busy_idle"}, busy_o, 1'b0);
        chk_result({tag, "_hold"}, e_sig, e_exp, k, e_zero, e_uf);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk_result("rst", '0, '0, 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        run_op("norm2",   26'h0800000, 8'd100, 1'b0, 1'b0, 2,  26'h2000000, 8'd98,  1'b0, 1'b0);
        run_op("already", 26'h2000001, 8'd50,  1'b0, 1'b0, 0,  26'h2000001, 8'd50,  1'b0, 1'b0);
        run_op("uflow",   26'h0000001, 8'd3,   1'b0, 1'b0, 3,  26'h0000008, 8'd0,   1'b0, 1'b1);
        run_op("zero",    26'h0000000, 8'd77,  1'b0, 1'b0, 0,  26'h0000000, 8'd0,   1'b1, 1'b0);
        run_op("exp0",    26'h0000100, 8'd0,   1'b0, 1'b0, 0,  26'h0000100, 8'd0,   1'b0, 1'b1);
        run_op("msb_e0",  26'h2000000, 8'd0,   1'b0, 1'b0, 0,  26'h2000000, 8'd0,   1'b0, 1'b0);
        run_op("maxk",    26'h0000001, 8'd200, 1'b0, 1'b0, 25, 26'h2000000, 8'd175, 1'b0, 1'b0);
        run_op("poke",    26'h0800000, 8'd100, 1'b0, 1'b1, 2,  26'h2000000, 8'd98,  1'b0, 1'b0);

        // Reset during the second shift: outputs clear at once, no done_o.
        significand_i = 26'h0800000;
        exponent_i    = 8'd100;
        start_i       = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("abort_cnt_before", shift_count_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        chk_result("abort", '0, '0, 0, 1'b0, 1'b0);
        begin
            int dones = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (done_o) dones++;
            end
            chk("abort_no_done", dones, 0);
        end
        rst = 1'b0;
        run_op("fresh",   26'h0800000, 8'd100, 1'b0, 1'b0, 2,  26'h2000000, 8'd98,  1'b0, 1'b0);

`ifdef NORM_SHIFT_GUARD_EN
        run_op("guard",   26'h1000000, 8'd10,  1'b1, 1'b0, 1,  26'h2000001, 8'd9,   1'b0, 1'b0);
        run_op("guard2",  26'h0800000, 8'd10,  1'b1, 1'b0, 2,  26'h2000002, 8'd8,   1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
